// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory bus responder: FSM state codes and op codes.
package mem_bus_responder_pkg;

    localparam logic [1:0] MB_IDLE    = 2'd0;
    localparam logic [1:0] MB_WAIT    = 2'd1;
    localparam logic [1:0] MB_DONE    = 2'd2;
    localparam logic [1:0] MB_RELEASE = 2'd3;

    localparam logic MB_OP_READ  = 1'b0;
    localparam logic MB_OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port synchronous RAM with write enable and registered read; kept apart
// from the responder FSM so it can map onto block RAM.
module mem_bus_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write on a shared address; the responder never relies on it.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: captures read/write strobes, completes after LATENCY
// enabled cycles with a broadcast pulse. Define MEM_BUS_ERR_EN for range checking.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_oe,
    input  logic [ADDR_W-1:0] addr_q,
    input  logic [DATA_W-1:0] data_q,
    input  logic              read_q,
    input  logic              write_q,
    output logic              is_bus_busy,
    output logic [ADDR_W-1:0] addr_bc,
    output logic [DATA_W-1:0] data_bc,
    output logic              read_dn,
    output logic              write_dn
`ifdef MEM_BUS_ERR_EN
    ,
    output logic              bus_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [1:0]        state;
    logic              op;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              in_range;

`ifdef MEM_BUS_ERR_EN
    assign in_range = ({1'b0, addr_r} < (ADDR_W+1)'(DEPTH));
`else
    assign in_range = 1'b1;
`endif

    // In IDLE the RAM tracks the incoming address so LATENCY==1 still has read
    // data ready in DONE; afterwards it stays on the captured address.
    assign ram_addr = (state == MB_IDLE) ? addr_q[IDX_W-1:0] : addr_r[IDX_W-1:0];
    assign ram_we   = clk_oe && (state == MB_DONE) && (op == MB_OP_WRITE) && in_range;

    mem_bus_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (clk_oe),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_r),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MB_IDLE;
            op          <= MB_OP_READ;
            addr_r      <= '0;
            data_r      <= '0;
            cnt         <= '0;
            is_bus_busy <= 1'b0;
            addr_bc     <= '0;
            data_bc     <= '0;
            read_dn     <= 1'b0;
            write_dn    <= 1'b0;
`ifdef MEM_BUS_ERR_EN
            bus_err     <= 1'b0;
`endif
        end else if (clk_oe) begin
            case (state)
                MB_IDLE: begin
                    if (read_q || write_q) begin
                        addr_r      <= addr_q;
                        data_r      <= data_q;
                        op          <= write_q ? MB_OP_WRITE : MB_OP_READ;
                        is_bus_busy <= 1'b1;
                        cnt         <= CNT_W'(LATENCY - 1);
                        state       <= (LATENCY == 1) ? MB_DONE : MB_WAIT;
                    end
                end
                MB_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= MB_DONE;
                end
                MB_DONE: begin
                    addr_bc <= addr_r;
                    if (op == MB_OP_WRITE) begin
                        data_bc  <= data_r;
                        write_dn <= 1'b1;
                    end else begin
                        data_bc <= in_range ? ram_rdata : '0;
                        read_dn <= 1'b1;
                    end
`ifdef MEM_BUS_ERR_EN
                    bus_err <= ~in_range;
`endif
                    state <= MB_RELEASE;
                end
                default: begin
                    read_dn     <= 1'b0;
                    write_dn    <= 1'b0;
                    is_bus_busy <= 1'b0;
`ifdef MEM_BUS_ERR_EN
                    bus_err     <= 1'b0;
`endif
                    state       <= MB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed and randomized transactions against a
// word-array model with timing derived from LATENCY.
module tb_mem_bus_responder;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
`ifdef MEM_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clk_oe = 1'b0;
    logic [ADDR_W-1:0] addr_q = '0;
    logic [DATA_W-1:0] data_q = '0;
    logic              read_q = 1'b0;
    logic              write_q = 1'b0;
    logic              is_bus_busy;
    logic [ADDR_W-1:0] addr_bc;
    logic [DATA_W-1:0] data_bc;
    logic              read_dn;
    logic              write_dn;
`ifdef MEM_BUS_ERR_EN
    logic              bus_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] model [int];

    mem_bus_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_oe      (clk_oe),
        .addr_q      (addr_q),
        .data_q      (data_q),
        .read_q      (read_q),
        .write_q     (write_q),
        .is_bus_busy (is_bus_busy),
        .addr_bc     (addr_bc),
        .data_bc     (data_bc),
        .read_dn     (read_dn),
        .write_dn    (write_dn)
`ifdef MEM_BUS_ERR_EN
        ,
        .bus_err     (bus_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit oe);
        clk_oe = oe;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One bus transaction; k counts enabled edges after the capture edge.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit stall, input bit inject);
        bit          oor, known, is_wr, oe;
        logic [31:0] exp_d;
        int          idx, k, guard;
        is_wr = wr;
        idx   = int'(a % DEPTH);
        oor   = ERR_EN && (a >= DEPTH);
        known = 1'b1;
        if (is_wr) begin
            exp_d = d;
            if (!oor) model[idx] = d;
        end else begin
            known = oor || model.exists(idx);
            exp_d = oor ? 32'h0 : (model.exists(idx) ? model[idx] : 32'hx);
        end
        addr_q = a; data_q = d; read_q = rd; write_q = wr;
        step(1'b1);
        read_q = 1'b0; write_q = 1'b0;
        addr_q = $urandom; data_q = $urandom;
        k = 0;
        check("busy_cap", {63'd0, is_bus_busy}, 64'd1);
        check("dn_cap", {62'd0, read_dn, write_dn}, 64'd0);
        guard = 0;
        while (k < LATENCY + 1 && guard < 100) begin
            oe = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (inject && k == 0) begin
                read_q = 1'b1;
                addr_q = 32'h30;
            end
            step(oe);
            read_q = 1'b0;
            if (oe) k++;
            guard++;
            check("busy", {63'd0, is_bus_busy}, {63'd0, k <= LATENCY});
            check("read_dn", {63'd0, read_dn}, {63'd0, (k == LATENCY) && !is_wr});
            check("write_dn", {63'd0, write_dn}, {63'd0, (k == LATENCY) && is_wr});
            if (k >= LATENCY) begin
                check("addr_bc", {32'd0, addr_bc}, {32'd0, a});
                if (known) check("data_bc", {32'd0, data_bc}, {32'd0, exp_d});
            end
`ifdef MEM_BUS_ERR_EN
            check("bus_err", {63'd0, bus_err}, {63'd0, (k == LATENCY) && oor});
`endif
        end
        if (guard >= 100) check("timeout", 64'(k), 64'(LATENCY + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {63'd0, is_bus_busy}, 64'd0);
        check({tag, "_dn"}, {62'd0, read_dn, write_dn}, 64'd0);
        check({tag, "_addr_bc"}, {32'd0, addr_bc}, 64'd0);
        check({tag, "_data_bc"}, {32'd0, data_bc}, 64'd0);
`ifdef MEM_BUS_ERR_EN
        check({tag, "_bus_err"}, {63'd0, bus_err}, 64'd0);
`endif
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step(1'b1);

        // Write then read-back, no stalls
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

        // Collision: write wins
        txn(1'b1, 1'b1, 32'h20, 32'h5, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);

        // Strobe while busy is ignored
        txn(1'b0, 1'b1, 32'h30, 32'hCAFE0030, 1'b0, 1'b1);
        step(1'b1);
        check("no_extra_dn", {62'd0, read_dn, write_dn}, 64'd0);
        check("no_extra_busy", {63'd0, is_bus_busy}, 64'd0);

        // Reset aborts a pending write
        txn(1'b0, 1'b1, 32'h40, 32'h1234, 1'b0, 1'b0);
        addr_q = 32'h40; data_q = 32'h77; write_q = 1'b1;
        step(1'b1);
        write_q = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);

        // Out-of-range write, then read of its wrapped alias
        txn(1'b0, 1'b1, 32'h3, 32'hA5A5A5A5, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 32'(DEPTH + 3), 32'h3C3C3C3C, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 32'h3, 32'h0, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 32'(DEPTH + 3), 32'h0, 1'b0, 1'b0);

        // Randomized traffic with clk_oe stalls
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 3);
            a = ($urandom_range(0, 7) == 0) ? 32'(DEPTH + $urandom_range(0, 15))
                                            : 32'($urandom_range(0, 15));
            txn(sel != 1, sel == 1 || sel == 2, a, $urandom, 1'b1, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side end of the processor register/data bus: services the single-cycle `read_q`/`write_q` strobes issued by register managers.
- Holds the bus busy while it works, then broadcasts the completed address and data with a one-cycle `read_dn`/`write_dn` pulse. Every requester can match its pending address, and can snoop writes.
- Contains a word-addressed RAM of DEPTH words and a fixed-latency response FSM.

Parameters:
- ADDR_W, 32, address width (matches `ADDR_SIZE` in sizes.v)
- DATA_W, 32, data width (matches `DATA_SIZE` in sizes.v)
- DEPTH, 1024, number of words in internal RAM
- LATENCY, 2, clk_oe=1 cycles between request capture and completion pulse (min 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_oe  in  1  phase enable; the FSM advances only on posedge clk with clk_oe==1
- addr_q  in  ADDR_W  requester address (valid while read_q/write_q high)
- data_q  in  DATA_W  requester write data (valid with write_q)
- read_q  in  1  read request strobe
- write_q  in  1  write request strobe
- is_bus_busy  out  1  high from capture until completion pulse ends
- addr_bc  out  ADDR_W  completed-transaction address broadcast
- data_bc  out  DATA_W  read data, or write data echo
- read_dn  out  1  one-cycle read completion pulse
- write_dn  out  1  one-cycle write completion pulse

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0 and the FSM is IDLE.
  - RAM contents are not cleared.
  - Reset mid-transaction aborts it: no dn pulse, and a pending write is not committed.
- States:
  - IDLE: if read_q or write_q on an enabled cycle, capture addr_q, data_q and the op; set is_bus_busy=1; load counter=LATENCY-1; go to WAIT.
  - WAIT: decrement the counter each enabled cycle; at 0 go to DONE.
  - DONE: perform the access and drive the broadcast (see below); go to RELEASE.
  - RELEASE: read_dn/write_dn=0; is_bus_busy=0; addr_bc/data_bc hold their last values; go to IDLE.
- DONE, write: RAM[addr mod DEPTH]=data; addr_bc=addr; data_bc=data; write_dn=1 for exactly one enabled cycle.
- DONE, read: data_bc=RAM[addr mod DEPTH] (synchronous RAM, read issued on WAIT→DONE edge); addr_bc=addr; read_dn=1.
- Latency: request captured in enabled cycle N; dn pulse in enabled cycle N+LATENCY; next request accepted no earlier than N+LATENCY+2.
- read_q and write_q high together: write wins, the read is dropped. Requesters re-issue on rw_halt, so no queueing.
- Strobes arriving while not IDLE are ignored and no flag is raised. Requesters must not strobe while is_bus_busy==1.
- Read after write to the same address returns the new data (write is committed in DONE, before any later read).
- Addresses ≥ DEPTH wrap using the low clog2(DEPTH) bits, unless `MEM_BUS_ERR_EN` is defined.
- Clock cycles with clk_oe==0 change no state; outputs hold.

Optional Feature:
- Macro: `MEM_BUS_ERR_EN`.
- When defined:
  - Adds output bus_err (1 bit).
  - An out-of-range address (addr ≥ DEPTH) completes normally (dn pulse, broadcast), but a write does not touch RAM and a read returns data_bc=0.
  - bus_err=1 for the same cycle as the dn pulse.
- When undefined: the port is absent and addresses wrap.

Decomposition:
- Shared package/include (mem_bus_defs.v):
  - FSM state codes `MB_IDLE`/`MB_WAIT`/`MB_DONE`/`MB_RELEASE` (2-bit).
  - Op codes `MB_OP_READ`/`MB_OP_WRITE`.
  - Width macros reused from sizes.v.
- Sub-module: mem_bus_ram, a single-port synchronous RAM (DATA_W×DEPTH, write-enable, registered read). It keeps the FSM separate from the storage for later FPGA block-RAM mapping.

Test Plan:
- Write: write_q with addr_q=0x10, data_q=0xDEADBEEF, LATENCY=2. Expect is_bus_busy=1 next enabled cycle and write_dn=1 two enabled cycles after capture, with addr_bc=0x10, data_bc=0xDEADBEEF. Busy drops one cycle later.
- Read-back: read_q at addr 0x10 after the write above. Expect read_dn pulse with data_bc=0xDEADBEEF, addr_bc=0x10, exactly LATENCY enabled cycles after capture.
- Collision: read_q and write_q together at addr 0x20, data 0x5. Expect only write_dn, and a subsequent read of 0x20 returns 0x5.
- Busy drop: read_q at addr 0x30 issued while busy. Expect no capture, no second dn pulse, and busy timing unchanged.
- Reset abort: rst_n low during WAIT of a write to 0x40, data 0x77. Expect all outputs 0 immediately and RAM[0x40] unchanged.
- Range check (with `MEM_BUS_ERR_EN`): write to addr DEPTH+3. Expect write_dn and bus_err together, and a read of addr 3 returns its old value. Without the macro, a read of addr 3 returns the written data.
